fetch_unit: RTL and testbench

- PC and fetch stage that drives the instruction memory's read_address and captures the returned instruction into an IF/ID register for the decoder.
- Computes next-PC for sequential, branch, jump and jump-register redirects.
- Supports stall and flush.
- Detects a halt word and out-of-range or misaligned fetches.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Purpose: PC register and fetch stage; computes next PC and fills the IF/ID register.
// Latency: an instruction at pc appears on if_id_instr one edge after pc presents it.
// Backpressure: stall holds pc and IF/ID; redirects override stall and flush IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS  = 21,
    parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] read_address,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] redirect_pc4,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] jr_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [1:0]  SEL_NONE   = 2'b00;
    localparam logic [1:0]  SEL_BRANCH = 2'b01;
    localparam logic [1:0]  SEL_JUMP   = 2'b10;
    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_pc4_q;
    logic        if_id_valid_q;
    logic        halted_q;
    logic        fault_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        redirect_req;
    logic        bad_pc;

    // Sequential successor and the three redirect targets; all wrap modulo 2^32.
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = redirect_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jump_target   = {redirect_pc4[31:28], target26, 2'b00};
    assign redirect_req  = (redirect_sel != SEL_NONE);

    // A fetch is bad when the word address is misaligned or beyond the memory.
    assign bad_pc = (pc_q[1:0] != 2'b00) || ((pc_q >> 2) >= MEM_WORDS_W);

    // Select the redirect destination; jr uses the register value untouched.
    always_comb begin
        redirect_target = jr_target;
        case (redirect_sel)
            SEL_BRANCH: redirect_target = branch_target;
            SEL_JUMP:   redirect_target = jump_target;
            default:    redirect_target = jr_target;
        endcase
    end

    // Fetch FSM: pc update, IF/ID capture and the sticky halted/fault flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_id_instr_q <= 32'd0;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    // One settling cycle: memory sees RESET_PC before first capture.
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_req) begin
                        // Redirect beats a bad pc: the new target gets its own check next edge.
                        pc_q          <= redirect_target;
                        if_id_valid_q <= 1'b0;
                    end else if (bad_pc) begin
                        state_q       <= ST_FAULT;
                        fault_q       <= 1'b1;
                        if_id_valid_q <= 1'b0;
                    end else if (stall) begin
                        pc_q          <= pc_q;
                    end else if (instruction == HALT_INSTR) begin
                        // The halt word itself is handed to decode, then fetch freezes.
                        if_id_instr_q <= instruction;
                        if_id_pc4_q   <= pc_plus4;
                        if_id_valid_q <= 1'b1;
                        state_q       <= ST_HALTED;
                        halted_q      <= 1'b1;
                    end else begin
                        if_id_instr_q <= instruction;
                        if_id_pc4_q   <= pc_plus4;
                        if_id_valid_q <= 1'b1;
                        pc_q          <= pc_plus4;
                    end
                end
                ST_HALTED: begin
                    if_id_valid_q <= 1'b0;
                end
                default: begin
                    if_id_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign read_address = pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_pc4    = if_id_pc4_q;
    assign if_id_valid  = if_id_valid_q;
    assign halted       = halted_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] ra;
        logic        v;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        h;
        logic        f;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] read_address;
    logic [31:0] instruction;
    logic        stall;
    logic [1:0]  redirect_sel;
    logic [31:0] redirect_pc4;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] jr_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:20];
    exp_t        sb [$];
    int          n_checks;
    int          n_pass;
    int          step_idx;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (21),
        .HALT_INSTR(32'h0000_000C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_address(read_address),
        .instruction (instruction),
        .stall       (stall),
        .redirect_sel(redirect_sel),
        .redirect_pc4(redirect_pc4),
        .imm16       (imm16),
        .target26    (target26),
        .jr_target   (jr_target),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: same-cycle read, poison outside the valid range.
    always_comb begin
        instruction = 32'hDEAD_BEEF;
        if (read_address[1:0] == 2'b00 && read_address[31:2] < 30'd21)
            instruction = mem[read_address[6:2]];
    end

    function automatic exp_t snapshot();
        exp_t s;
        s.ra  = read_address;
        s.v   = if_id_valid;
        s.ins = if_id_instr;
        s.p4  = if_id_pc4;
        s.h   = halted;
        s.f   = fault;
        return s;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got ra=%h v=%b instr=%h pc4=%h halted=%b fault=%b, want ra=%h v=%b instr=%h pc4=%h halted=%b fault=%b",
                     name, got.ra, got.v, got.ins, got.p4, got.h, got.f,
                     want.ra, want.v, want.ins, want.p4, want.h, want.f);
        end
    endtask

    // Monitor: after every active edge, compare the DUT against the oldest expectation.
    initial begin
        step_idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t want;
                want = sb.pop_front();
                check($sformatf("step%0d", step_idx), snapshot(), want);
                step_idx++;
            end
        end
    end

    // Issue one cycle: inputs already set by caller; expectation is the state after the next edge.
    task automatic cyc(input logic [31:0] ra, input logic v, input logic [31:0] ins,
                       input logic [31:0] p4, input logic h, input logic f);
        exp_t e;
        e.ra  = ra;
        e.v   = v;
        e.ins = ins;
        e.p4  = p4;
        e.h   = h;
        e.f   = f;
        sb.push_back(e);
        @(negedge clk);
        stall        = 1'b0;
        redirect_sel = 2'b00;
    endtask

    // Asynchronous reset mid-cycle with a redirect pending; released on a falling edge.
    task automatic do_reset(input string name);
        @(posedge clk);
        #3;
        redirect_sel = 2'b01;
        rst_n        = 1'b0;
        #1;
        check(name, snapshot(), '0);
        redirect_sel = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b1;
        stall        = 1'b0;
        redirect_sel = 2'b00;
        redirect_pc4 = 32'd0;
        imm16        = 16'd0;
        target26     = 26'd0;
        jr_target    = 32'd0;
        for (int i = 0; i < 21; i++) mem[i] = 32'h11 * (i + 1);

        // Sequential fetch, stall, branch/jump/jr redirects, run off the end into fault.
        do_reset("reset0");
        cyc(32'd0, 0, 32'd0, 32'd0, 0, 0);                 // BOOT
        cyc(32'd4, 1, 32'h11, 32'd4, 0, 0);
        cyc(32'd8, 1, 32'h22, 32'd8, 0, 0);
        stall = 1'b1;
        cyc(32'd8, 1, 32'h22, 32'd8, 0, 0);
        stall = 1'b1;
        cyc(32'd8, 1, 32'h22, 32'd8, 0, 0);
        cyc(32'd12, 1, 32'h33, 32'd12, 0, 0);
        redirect_sel = 2'b01; redirect_pc4 = 32'd8; imm16 = 16'hFFFE;
        cyc(32'd0, 0, 32'h33, 32'd12, 0, 0);
        cyc(32'd4, 1, 32'h11, 32'd4, 0, 0);
        stall = 1'b1; redirect_sel = 2'b10; redirect_pc4 = 32'd8; target26 = 26'd3;
        cyc(32'd12, 0, 32'h11, 32'd4, 0, 0);
        cyc(32'd16, 1, 32'h44, 32'd16, 0, 0);
        redirect_sel = 2'b11; jr_target = 32'd20;
        cyc(32'd20, 0, 32'h44, 32'd16, 0, 0);
        cyc(32'd24, 1, 32'h66, 32'd24, 0, 0);
        for (int i = 6; i <= 20; i++)
            cyc((i + 1) * 4, 1, 32'h11 * (i + 1), (i + 1) * 4, 0, 0);
        cyc(32'd84, 0, 32'h165, 32'd84, 0, 1);             // out of range
        redirect_sel = 2'b11; jr_target = 32'd0;
        cyc(32'd84, 0, 32'h165, 32'd84, 0, 1);             // FAULT ignores redirect

        // Jump keeps upper nibble of pc4; redirect overrides a bad pc; jr to misaligned faults.
        do_reset("reset1");
        cyc(32'd0, 0, 32'd0, 32'd0, 0, 0);
        cyc(32'd4, 1, 32'h11, 32'd4, 0, 0);
        redirect_sel = 2'b10; redirect_pc4 = 32'h9000_0000; target26 = 26'd1;
        cyc(32'h9000_0004, 0, 32'h11, 32'd4, 0, 0);
        redirect_sel = 2'b11; jr_target = 32'd8;
        cyc(32'd8, 0, 32'h11, 32'd4, 0, 0);
        cyc(32'd12, 1, 32'h33, 32'd12, 0, 0);
        redirect_sel = 2'b11; jr_target = 32'd6;
        cyc(32'd6, 0, 32'h33, 32'd12, 0, 0);
        cyc(32'd6, 0, 32'h33, 32'd12, 0, 1);

        // Halt word at address 12: captured, then valid drops and pc freezes.
        mem[3] = 32'h0000_000C;
        do_reset("reset2");
        cyc(32'd0, 0, 32'd0, 32'd0, 0, 0);
        cyc(32'd4, 1, 32'h11, 32'd4, 0, 0);
        cyc(32'd8, 1, 32'h22, 32'd8, 0, 0);
        cyc(32'd12, 1, 32'h33, 32'd12, 0, 0);
        cyc(32'd12, 1, 32'h0000_000C, 32'd16, 1, 0);
        redirect_sel = 2'b10; redirect_pc4 = 32'd0; target26 = 26'd5;
        cyc(32'd12, 0, 32'h0000_000C, 32'd16, 1, 0);
        stall = 1'b1;
        cyc(32'd12, 0, 32'h0000_000C, 32'd16, 1, 0);
        mem[3] = 32'h44;

        // Reset out of HALTED, then fetch restarts from address 0.
        do_reset("reset3");
        cyc(32'd0, 0, 32'd0, 32'd0, 0, 0);
        cyc(32'd4, 1, 32'h11, 32'd4, 0, 0);

        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
